fetch_stage: RTL and testbench

Instruction-fetch stage of the 5-stage MIPS pipeline. It holds the program counter and drives the byte address into the instruction ROM, which returns a big-endian 32-bit word combinationally. It latches that word into the IF/ID pipeline register for the decode stage. It also handles stall, flush and branch/jump redirect from later stages.

---
 rtl/fetch_stage_if.sv | 12 +
 rtl/fetch_stage.sv | 79 +++++++
 tb/tb_fetch_stage.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/fetch_stage_if.sv
// Instruction-ROM bus between the fetch stage (master) and the ROM (slave).
// The ROM answers combinationally: imem_data is the word at imem_addr in the same cycle.
interface fetch_stage_if #(
   parameter int ADDR_WIDTH = 10,
   parameter int DATA_WIDTH = 32
);
   logic [ADDR_WIDTH-1:0] imem_addr;
   logic [DATA_WIDTH-1:0] imem_data;

   modport master (output imem_addr, input imem_data);
   modport slave  (input imem_addr, output imem_data);
endinterface

// File: rtl/fetch_stage.sv
// MIPS instruction-fetch stage: program counter, ROM addressing and the IF/ID register,
// with stall, flush and branch/jump redirect from later pipeline stages.
module fetch_stage #(
   parameter int ADDR_WIDTH = 10,
   parameter int DATA_WIDTH = 32,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0,
   parameter int CNT_WIDTH  = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  stall,
   input  logic                  flush,
   input  logic                  redirect_valid,
   input  logic [ADDR_WIDTH-1:0] redirect_target,
   fetch_stage_if.master         imem,
   output logic [DATA_WIDTH-1:0] if_id_instr,
   output logic [ADDR_WIDTH-1:0] if_id_pc,
   output logic [ADDR_WIDTH-1:0] if_id_pc_plus4,
   output logic                  if_id_valid,
   output logic                  align_err,
   output logic [CNT_WIDTH-1:0]  fetch_count
);

   logic [ADDR_WIDTH-1:0] pc;
   logic [ADDR_WIDTH-1:0] pc_plus4;
   logic [ADDR_WIDTH-1:0] pc_next;
   logic                  load;

   // Adding 4 at ADDR_WIDTH bits gives the required modulo-2^ADDR_WIDTH wrap.
   assign pc_plus4      = pc + ADDR_WIDTH'(4);
   assign imem.imem_addr = pc;

   // if_id_valid qualifies the IF/ID register for decode; there is no back-pressure
   // handshake, decode holds it with stall and kills it with flush.
   assign load = !flush && !stall;

   always_comb begin
      pc_next = pc_plus4;
      if (redirect_valid)
         pc_next = {redirect_target[ADDR_WIDTH-1:2], 2'b00};
      else if (stall)
         pc_next = pc;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pc <= RESET_PC;
      end else begin
         pc <= pc_next;
      end
   end

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         if_id_instr    <= '0;
         if_id_pc       <= '0;
         if_id_pc_plus4 <= '0;
         if_id_valid    <= 1'b0;
      end else if (load) begin
         if_id_instr    <= imem.imem_data;
         if_id_pc       <= pc;
         if_id_pc_plus4 <= pc_plus4;
         if_id_valid    <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         align_err   <= 1'b0;
         fetch_count <= '0;
      end else begin
         if (redirect_valid && (redirect_target[1:0] != 2'b00))
            align_err <= 1'b1;
         if (load)
            fetch_count <= fetch_count + CNT_WIDTH'(1);
      end
   end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: a reference model tracks the default instance every cycle,
// directed vectors pin literal values, and a second instance covers the PC wrap.
module tb_fetch_stage;

   localparam int AW = 10;
   localparam int DW = 32;
   localparam int CW = 32;

   // clock / reset
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst, stall, flush, redirect_valid;
   logic [AW-1:0] redirect_target;
   logic          rst_b;

   logic [DW-1:0] rom [0:255];

   fetch_stage_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) imem_a ();
   fetch_stage_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) imem_b ();
   assign imem_a.imem_data = rom[imem_a.imem_addr[AW-1:2]];
   assign imem_b.imem_data = rom[imem_b.imem_addr[AW-1:2]];

   logic [DW-1:0] a_instr, b_instr;
   logic [AW-1:0] a_pc, a_pc4, b_pc, b_pc4;
   logic          a_valid, b_valid, a_err, b_err;
   logic [CW-1:0] a_cnt, b_cnt;

   fetch_stage #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RESET_PC(10'h000), .CNT_WIDTH(CW)) dut (
      .clk(clk), .rst(rst), .stall(stall), .flush(flush),
      .redirect_valid(redirect_valid), .redirect_target(redirect_target),
      .imem(imem_a),
      .if_id_instr(a_instr), .if_id_pc(a_pc), .if_id_pc_plus4(a_pc4),
      .if_id_valid(a_valid), .align_err(a_err), .fetch_count(a_cnt)
   );

   fetch_stage #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RESET_PC(10'h3F8), .CNT_WIDTH(CW)) dut_wrap (
      .clk(clk), .rst(rst_b), .stall(1'b0), .flush(1'b0),
      .redirect_valid(1'b0), .redirect_target(10'h000),
      .imem(imem_b),
      .if_id_instr(b_instr), .if_id_pc(b_pc), .if_id_pc_plus4(b_pc4),
      .if_id_valid(b_valid), .align_err(b_err), .fetch_count(b_cnt)
   );

   // scoreboard counters
   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // reference model: whole-instruction view of the stage, ROM looked up by byte address
   int unsigned m_pc, m_ipc, m_ipc4, m_cnt;
   logic [DW-1:0] m_instr;
   bit m_valid, m_err, m_ok = 0;

   function automatic logic [DW-1:0] rom_at(input int unsigned byte_addr);
      return rom[byte_addr / 4];
   endfunction

   always @(posedge clk) begin
      int unsigned old_pc;
      old_pc = m_pc;
      if (rst) begin
         m_pc = 0; m_instr = '0; m_ipc = 0; m_ipc4 = 0; m_valid = 0; m_err = 0; m_cnt = 0;
         m_ok = 1;
      end else if (m_ok) begin
         if (redirect_valid) begin
            m_pc = (redirect_target / 4) * 4;
            if (redirect_target % 4 != 0) m_err = 1;
         end else if (!stall) begin
            m_pc = (old_pc + 4) % 1024;
         end
         if (flush) begin
            m_instr = '0; m_ipc = 0; m_ipc4 = 0; m_valid = 0;
         end else if (!stall) begin
            m_instr = rom_at(old_pc); m_ipc = old_pc; m_ipc4 = (old_pc + 4) % 1024;
            m_valid = 1; m_cnt = m_cnt + 1;
         end
      end
   end

   always @(negedge clk) begin
      if (m_ok) begin
         chk("m_addr",  32'(imem_a.imem_addr), m_pc);
         chk("m_instr", a_instr, m_instr);
         chk("m_pc",    32'(a_pc), m_ipc);
         chk("m_pc4",   32'(a_pc4), m_ipc4);
         chk("m_valid", 32'(a_valid), 32'(m_valid));
         chk("m_err",   32'(a_err), 32'(m_err));
         chk("m_cnt",   a_cnt, m_cnt);
      end
   end

   // driver tasks
   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic drive(input logic s, input logic f, input logic rv, input logic [AW-1:0] tgt);
      stall = s; flush = f; redirect_valid = rv; redirect_target = tgt;
   endtask

   task automatic chk_ifid(input string name, input logic [DW-1:0] ins, input logic [AW-1:0] pc,
                           input logic [AW-1:0] pc4, input logic v);
      chk({name, "_instr"}, a_instr, ins);
      chk({name, "_pc"},    32'(a_pc), 32'(pc));
      chk({name, "_pc4"},   32'(a_pc4), 32'(pc4));
      chk({name, "_valid"}, 32'(a_valid), 32'(v));
   endtask

   initial begin
      for (int i = 0; i < 256; i++) rom[i] = 32'hC0DE0000 | 32'(i);
      rst = 1'b1; rst_b = 1'b1;
      drive(1'b0, 1'b0, 1'b0, 10'h000);
      cyc(2);
      chk("rst_addr", 32'(imem_a.imem_addr), 32'h000);
      chk_ifid("rst", 32'h0, 10'h000, 10'h000, 1'b0);
      chk("rst_cnt", a_cnt, 32'd0);
      chk("rst_err", 32'(a_err), 32'd0);
      chk("wrap_rst_addr", 32'(imem_b.imem_addr), 32'h3F8);
      rst = 1'b0; rst_b = 1'b0;

      // free run, with the wrap instance alongside
      cyc(1);
      chk("run_addr1", 32'(imem_a.imem_addr), 32'h004);
      chk_ifid("run_w0", 32'hC0DE0000, 10'h000, 10'h004, 1'b1);
      chk("wrap_addr1", 32'(imem_b.imem_addr), 32'h3FC);
      chk("wrap_pc1", 32'(b_pc), 32'h3F8);
      chk("wrap_pc4_1", 32'(b_pc4), 32'h3FC);
      cyc(1);
      chk("run_addr2", 32'(imem_a.imem_addr), 32'h008);
      chk_ifid("run_w1", 32'hC0DE0001, 10'h004, 10'h008, 1'b1);
      chk("wrap_addr2", 32'(imem_b.imem_addr), 32'h000);
      chk("wrap_instr2", b_instr, 32'hC0DE00FF);
      chk("wrap_pc2", 32'(b_pc), 32'h3FC);
      chk("wrap_pc4_2", 32'(b_pc4), 32'h000);
      cyc(1);
      chk("run_addr3", 32'(imem_a.imem_addr), 32'h00C);
      chk_ifid("run_w2", 32'hC0DE0002, 10'h008, 10'h00C, 1'b1);
      chk("run_cnt3", a_cnt, 32'd3);

      // restart, then stall two cycles with PC=0x008
      rst = 1'b1; cyc(1); rst = 1'b0;
      cyc(2);
      chk("pre_stall_addr", 32'(imem_a.imem_addr), 32'h008);
      drive(1'b1, 1'b0, 1'b0, 10'h000);
      for (int i = 0; i < 2; i++) begin
         cyc(1);
         chk("stall_addr", 32'(imem_a.imem_addr), 32'h008);
         chk_ifid("stall", 32'hC0DE0001, 10'h004, 10'h008, 1'b1);
         chk("stall_cnt", a_cnt, 32'd2);
      end
      drive(1'b0, 1'b0, 1'b0, 10'h000);
      cyc(1);
      chk_ifid("release_w2", 32'hC0DE0002, 10'h008, 10'h00C, 1'b1);
      chk("release_addr", 32'(imem_a.imem_addr), 32'h00C);
      chk("release_cnt", a_cnt, 32'd3);

      // taken branch with flush while PC=0x00C
      drive(1'b0, 1'b1, 1'b1, 10'h100);
      cyc(1);
      chk("redir_addr", 32'(imem_a.imem_addr), 32'h100);
      chk_ifid("redir_bubble", 32'h0, 10'h000, 10'h000, 1'b0);
      chk("redir_cnt", a_cnt, 32'd3);
      drive(1'b0, 1'b0, 1'b0, 10'h000);
      cyc(1);
      chk_ifid("redir_tgt", 32'hC0DE0040, 10'h100, 10'h104, 1'b1);
      chk("redir_addr2", 32'(imem_a.imem_addr), 32'h104);

      // misaligned redirect under stall: PC realigned, IF/ID held, sticky error
      drive(1'b1, 1'b0, 1'b1, 10'h102);
      cyc(1);
      chk("mis_addr", 32'(imem_a.imem_addr), 32'h100);
      chk("mis_err", 32'(a_err), 32'd1);
      chk_ifid("mis_hold", 32'hC0DE0040, 10'h100, 10'h104, 1'b1);
      drive(1'b0, 1'b0, 1'b0, 10'h000);
      cyc(3);
      chk("mis_sticky", 32'(a_err), 32'd1);

      // reset wins over simultaneous redirect and flush
      rst = 1'b1;
      drive(1'b1, 1'b1, 1'b1, 10'h102);
      cyc(1);
      chk("rst_ovr_addr", 32'(imem_a.imem_addr), 32'h000);
      chk("rst_ovr_valid", 32'(a_valid), 32'd0);
      chk("rst_ovr_cnt", a_cnt, 32'd0);
      chk("rst_ovr_err", 32'(a_err), 32'd0);
      rst = 1'b0;
      drive(1'b0, 1'b0, 1'b0, 10'h000);

      // short randomised tail checked only by the model
      for (int i = 0; i < 200; i++) begin
         drive(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 5) == 0),
               1'($urandom_range(0, 7) == 0), 10'($urandom_range(0, 1023)));
         cyc(1);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
